// File: rtl/tree_mult_pipe.sv
// Pipelined Wallace-tree multiplier with valid/ready streaming on both sides.
// Operands are sign-extended on capture, reduced by a 3:2 carry-save tree, then summed in the last stage.
module tree_mult_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [2:0]           in_flight
);
  localparam int PW  = 2 * WIDTH;
  localparam int NR  = WIDTH + 1;
  localparam int MID = STAGES - 2;

  typedef logic [NR-1:0][PW-1:0] rows_t;

  function automatic int num_levels();
    int n = NR;
    int l = 0;
    for (int j = 0; j < 64; j++) begin
      if (n > 2) begin
        n = 2 * (n / 3) + n % 3;
        l++;
      end
    end
    return l;
  endfunction

  localparam int LEVELS = num_levels();

  // One tree level: every full group of three rows becomes a sum row and a shifted carry row.
  function automatic rows_t csa_level(input rows_t r, input int n);
    rows_t o;
    int    g;
    o = '0;
    g = n / 3;
    for (int i = 0; i < NR / 3; i++) begin
      if (i < g) begin
        o[2*i]   = r[3*i] ^ r[3*i+1] ^ r[3*i+2];
        o[2*i+1] = ((r[3*i] & r[3*i+1]) | (r[3*i] & r[3*i+2]) | (r[3*i+1] & r[3*i+2])) << 1;
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (j < n % 3) o[2*g+j] = r[3*g+j];
    end
    return o;
  endfunction

  // Applies tree levels lo..hi-1; the row count of each level is tracked from the top.
  function automatic rows_t apply_levels(input rows_t r, input int lo, input int hi);
    rows_t t;
    int    n;
    t = r;
    n = NR;
    for (int k = 0; k < LEVELS; k++) begin
      if (k >= lo && k < hi) t = csa_level(t, n);
      n = 2 * (n / 3) + n % 3;
    end
    return t;
  endfunction

  function automatic logic [PW-1:0] final_sum(input rows_t r);
    return r[0] + r[1];
  endfunction

  logic            adv;
  logic            accept;
  logic            emit;
  logic [NR-1:0]   a_reg;
  logic [NR-1:0]   b_reg;
  logic            v1_reg;
  logic [PW-1:0]   a_wide;
  rows_t           pp0;
  rows_t           fin_rows;
  logic            fin_valid;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign accept   = in_valid & adv;
  assign emit     = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      v1_reg <= 1'b0;
    end else if (adv) begin
      a_reg  <= {is_signed & A[WIDTH-1], A};
      b_reg  <= {is_signed & B[WIDTH-1], B};
      v1_reg <= in_valid;
    end
  end

  // The top multiplier bit has negative weight: its row is inverted and the +1 rides in row 1, bit 0.
  assign a_wide = {{(WIDTH-1){a_reg[WIDTH]}}, a_reg};

  always_comb begin
    pp0 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pp0[i] = b_reg[i] ? (a_wide << i) : '0;
    end
    pp0[WIDTH]  = b_reg[WIDTH] ? ~(a_wide << WIDTH) : '0;
    pp0[1][0]   = b_reg[WIDTH];
  end

  if (MID == 0) begin : g_direct
    assign fin_rows  = apply_levels(pp0, 0, LEVELS);
    assign fin_valid = v1_reg;
  end else begin : g_mid
    rows_t            stage_rows [MID];
    rows_t            stage_in   [MID];
    logic [MID-1:0]   stage_valid;
    logic [MID-1:0]   valid_in;

    for (genvar gi = 0; gi < MID; gi++) begin : g_stage
      localparam int LO = (gi * LEVELS) / MID;
      localparam int HI = ((gi + 1) * LEVELS) / MID;
      if (gi == 0) begin : g_first
        assign stage_in[gi] = apply_levels(pp0, LO, HI);
        assign valid_in[gi] = v1_reg;
      end else begin : g_next
        assign stage_in[gi] = apply_levels(stage_rows[gi-1], LO, HI);
        assign valid_in[gi] = stage_valid[gi-1];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int s = 0; s < MID; s++) stage_rows[s] <= '0;
        stage_valid <= '0;
      end else if (adv) begin
        for (int s = 0; s < MID; s++) stage_rows[s] <= stage_in[s];
        stage_valid <= valid_in;
      end
    end

    assign fin_rows  = stage_rows[MID-1];
    assign fin_valid = stage_valid[MID-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (adv) begin
      out_valid <= fin_valid;
      result    <= fin_valid ? final_sum(fin_rows) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_flight <= '0;
    end else if (accept && !emit) begin
      in_flight <= in_flight + 3'd1;
    end else if (!accept && emit) begin
      in_flight <= in_flight - 3'd1;
    end
  end
endmodule

// File: tb/tb_tree_mult_pipe.sv
// Directed bench for tree_mult_pipe: a 32-bit/3-stage instance and an 8-bit/2-stage instance.
module tb_tree_mult_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, is_signed, out_valid, out_ready;
  logic [31:0] a, b;
  logic [63:0] result;
  logic [2:0]  in_flight;

  logic        in_valid8, in_ready8, signed8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;
  logic [2:0]  in_flight8;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  tree_mult_pipe #(.WIDTH(32), .STAGES(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .in_flight(in_flight)
  );

  tree_mult_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .is_signed(signed8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .in_flight(in_flight8)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int x, input int y, input logic s);
    in_valid  = v;
    a         = x;
    b         = y;
    is_signed = s;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    out_ready  = 1'b1;
    in_valid8  = 1'b0;
    a8         = 8'h00;
    b8         = 8'h00;
    signed8    = 1'b0;
    out_ready8 = 1'b1;

    #2;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_val("reset_result", result, 64'h0);
    check_val("reset_in_flight", 64'(in_flight), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_bit("release_in_ready", in_ready, 1'b1);

    // Single signed pair, latency two edges after accept.
    drive(1'b1, 50, -40, 1'b1);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    check_val("single_in_flight", 64'(in_flight), 64'd1);
    check_bit("single_lat0", out_valid, 1'b0);
    tick();
    check_bit("single_lat1", out_valid, 1'b0);
    tick();
    check_bit("single_valid", out_valid, 1'b1);
    check_val("single_result", result, 64'hFFFF_FFFF_FFFF_F830);
    tick();
    check_bit("single_drained", out_valid, 1'b0);
    check_val("single_flight0", 64'(in_flight), 64'd0);

    // Back-to-back stream.
    drive(1'b1, 90, 70, 1'b1);
    tick();
    drive(1'b1, -80, -65, 1'b1);
    tick();
    drive(1'b1, -10, 325, 1'b1);
    tick();
    check_val("stream0", result, 64'd6300);
    drive(1'b1, -999, 999, 1'b1);
    tick();
    check_val("stream1", result, 64'd5200);
    check_val("stream_full_flight", 64'(in_flight), 64'd3);
    drive(1'b0, 0, 0, 1'b0);
    tick();
    check_val("stream2", result, -64'sd3250);
    tick();
    check_val("stream3", result, -64'sd998001);
    tick();
    check_bit("stream_end_valid", out_valid, 1'b0);
    check_val("stream_end_result", result, 64'h0);

    // Same operands, unsigned then signed.
    drive(1'b1, 32'hFFFF_FFFF, 2, 1'b0);
    tick();
    drive(1'b1, 32'hFFFF_FFFF, 2, 1'b1);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    tick();
    check_val("unsigned_ffff_x2", result, 64'h0000_0001_FFFF_FFFE);
    tick();
    check_val("signed_m1_x2", result, 64'hFFFF_FFFF_FFFF_FFFE);

    // Signed corners.
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    tick();
    drive(1'b1, 98756, 0, 1'b1);
    tick();
    drive(1'b1, 98765, 1, 1'b1);
    tick();
    check_val("corner_minmin", result, 64'h4000_0000_0000_0000);
    drive(1'b0, 0, 0, 1'b0);
    tick();
    check_bit("corner_zero_valid", out_valid, 1'b1);
    check_val("corner_zero", result, 64'h0);
    tick();
    check_val("corner_one", result, 64'd98765);
    tick();

    // Back-pressure: fill with three pairs while the consumer stalls.
    out_ready = 1'b0;
    drive(1'b1, 3, 5, 1'b1);
    tick();
    drive(1'b1, -7, 9, 1'b1);
    tick();
    drive(1'b1, 12, -12, 1'b1);
    tick();
    check_bit("bp_out_valid", out_valid, 1'b1);
    check_bit("bp_in_ready", in_ready, 1'b0);
    check_val("bp_in_flight", 64'(in_flight), 64'd3);
    check_val("bp_result", result, 64'd15);
    drive(1'b1, 100, 100, 1'b1);
    tick();
    tick();
    check_val("bp_hold_result", result, 64'd15);
    check_val("bp_hold_flight", 64'(in_flight), 64'd3);
    check_bit("bp_hold_in_ready", in_ready, 1'b0);
    drive(1'b0, 0, 0, 1'b0);
    out_ready = 1'b1;
    #1;
    check_bit("bp_release_in_ready", in_ready, 1'b1);
    check_val("bp_emit0", result, 64'd15);
    tick();
    check_val("bp_emit1", result, -64'sd63);
    check_val("bp_flight2", 64'(in_flight), 64'd2);
    tick();
    check_val("bp_emit2", result, -64'sd144);
    check_val("bp_flight1", 64'(in_flight), 64'd1);
    tick();
    check_bit("bp_done_valid", out_valid, 1'b0);
    check_val("bp_done_flight", 64'(in_flight), 64'd0);
    check_val("bp_done_result", result, 64'h0);

    // WIDTH=8, STAGES=2 instance.
    in_valid8 = 1'b1;
    a8 = 8'h80;
    b8 = 8'h80;
    signed8 = 1'b1;
    tick();
    check_bit("w8_lat0", out_valid8, 1'b0);
    in_valid8 = 1'b1;
    a8 = 8'hFF;
    b8 = 8'hFF;
    signed8 = 1'b0;
    tick();
    in_valid8 = 1'b0;
    check_bit("w8_valid", out_valid8, 1'b1);
    check_val("w8_minmin", 64'(result8), 64'h4000);
    tick();
    check_val("w8_unsigned_ff", 64'(result8), 64'hFE01);
    tick();
    check_bit("w8_drained", out_valid8, 1'b0);

    // Reset with two pairs in flight, one of them already at the output.
    drive(1'b1, 11, 13, 1'b1);
    tick();
    drive(1'b1, -5, 4, 1'b1);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    tick();
    check_val("rst_pre_flight", 64'(in_flight), 64'd2);
    check_bit("rst_pre_valid", out_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_val("rst_in_flight", 64'(in_flight), 64'd0);
    check_val("rst_result", result, 64'h0);
    tick();
    reset = 1'b1;
    #1 check_bit("rst_release_in_ready", in_ready, 1'b1);
    tick();
    tick();
    tick();
    check_bit("rst_no_stale", out_valid, 1'b0);
    drive(1'b1, 7, 6, 1'b0);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    tick();
    check_bit("rst_next_lat", out_valid, 1'b0);
    tick();
    check_bit("rst_next_valid", out_valid, 1'b1);
    check_val("rst_next_result", result, 64'd42);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
